// File: rtl/monitor_view_ctrl.sv
// monitor_view_ctrl: debounced-button register viewer with manual/auto view rotation and freeze snapshot
module monitor_view_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ROTATE_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_n,
  input  logic [15:0] PC_reg,
  input  logic [7:0]  A_reg,
  input  logic [7:0]  X_reg,
  input  logic [7:0]  Y_reg,
  output logic [15:0] display_value,
  output logic [1:0]  view_sel,
  output logic        auto_on,
  output logic        frozen
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(ROTATE_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RT_MAX = RW'(ROTATE_CYCLES - 1);
  typedef enum logic {MANUAL, AUTO} mode_t;
  mode_t mode, mode_nx;
  logic [3:0] sync1, sync2, deb, deb_d, press;
  logic [DW-1:0] db_cnt [4];
  logic [RW-1:0] rot_cnt;
  logic [15:0] snap_pc, live_val, snap_val;
  logic [7:0] snap_a, snap_x, snap_y;
  logic [1:0] stepped;
  logic step, rot_hit;
  // two-flop synchronizer, released (1) out of reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end
  // per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb <= 4'hF;
      deb_d <= 4'hF;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 4; i++)
        if (sync2[i] == deb[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == DB_MAX) begin
          deb[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
    end
  end
  // press pulses, next view/mode and display source selection
  always_comb begin
    press = deb_d & ~deb;
    step = press[0] ^ press[1];
    stepped = press[0] ? view_sel + 2'd1 : view_sel - 2'd1;
    rot_hit = mode == AUTO && rot_cnt == RT_MAX && !press[3];
    mode_nx = press[3] ? (mode == AUTO ? MANUAL : AUTO) : mode;
    live_val = view_sel == 2'd0 ? PC_reg :
               {8'h00, view_sel == 2'd1 ? A_reg : view_sel == 2'd2 ? X_reg : Y_reg};
    snap_val = view_sel == 2'd0 ? snap_pc :
               {8'h00, view_sel == 2'd1 ? snap_a : view_sel == 2'd2 ? snap_x : snap_y};
  end
  // mode FSM, view selection, rotation timer, freeze snapshot and display register
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode <= MANUAL;
      auto_on <= 1'b0;
      view_sel <= 2'd0;
      rot_cnt <= '0;
      frozen <= 1'b0;
      snap_pc <= 16'h0000;
      snap_a <= 8'h00;
      snap_x <= 8'h00;
      snap_y <= 8'h00;
      display_value <= 16'h0000;
    end else begin
      mode <= mode_nx;
      auto_on <= mode_nx == AUTO;
      view_sel <= step ? stepped : rot_hit ? view_sel + 2'd1 : view_sel;
      rot_cnt <= (mode_nx == MANUAL || press[3] || step || rot_hit) ? '0 : rot_cnt + 1'b1;
      frozen <= frozen ^ press[2];
      if (press[2] && !frozen) begin
        snap_pc <= PC_reg;
        snap_a <= A_reg;
        snap_x <= X_reg;
        snap_y <= Y_reg;
      end
      display_value <= frozen ? snap_val : live_val;
    end
  end
endmodule

// File: tb/tb_monitor_view_ctrl.sv
// tb_monitor_view_ctrl: directed and randomized checks of monitor_view_ctrl against a behavioural model
module tb_monitor_view_ctrl;
  localparam int D = 4;
  localparam int R = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] btn_n = 4'hF;
  logic [15:0] pc = 16'h0000;
  logic [7:0] a = 8'h00, x = 8'h00, y = 8'h00;
  logic [15:0] display_value;
  logic [1:0] view_sel;
  logic auto_on, frozen;
  int errors = 0;
  int checks = 0;

  monitor_view_ctrl #(.DEBOUNCE_CYCLES(D), .ROTATE_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .PC_reg(pc), .A_reg(a), .X_reg(x), .Y_reg(y),
    .display_value(display_value), .view_sel(view_sel), .auto_on(auto_on), .frozen(frozen)
  );

  always #5 clk = ~clk;

  // behavioural model: a button level is accepted once the last D synchronized samples all disagree with it
  int m_view, m_rot;
  bit m_auto, m_frz, moved, all_diff;
  bit [3:0] m_lvl, m_press;
  bit [3:0] hist[$];
  logic [15:0] m_disp, s_pc;
  logic [7:0] s_a, s_x, s_y;

  function automatic logic [15:0] sel(int v, logic [15:0] p, logic [7:0] aa, logic [7:0] xx, logic [7:0] yy);
    return v == 0 ? p : {8'h00, v == 1 ? aa : v == 2 ? xx : yy};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_view = 0; m_rot = 0; m_auto = 0; m_frz = 0; m_disp = 16'h0000;
      s_pc = 16'h0000; s_a = 8'h00; s_x = 8'h00; s_y = 8'h00;
      m_lvl = 4'hF; m_press = 4'h0;
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back(4'hF);
    end else begin
      m_disp = m_frz ? sel(m_view, s_pc, s_a, s_x, s_y) : sel(m_view, pc, a, x, y);
      moved = m_press[0] != m_press[1];
      if (m_press[0] && !m_press[1]) m_view = (m_view + 1) % 4;
      if (m_press[1] && !m_press[0]) m_view = (m_view + 3) % 4;
      if (m_press[3]) begin
        m_auto = !m_auto;
        m_rot = 0;
      end else if (m_auto) begin
        if (moved) m_rot = 0;
        else if (m_rot == R - 1) begin
          m_rot = 0;
          m_view = (m_view + 1) % 4;
        end else m_rot++;
      end
      if (m_press[2]) begin
        if (!m_frz) begin s_pc = pc; s_a = a; s_x = x; s_y = y; end
        m_frz = !m_frz;
      end
      for (int b = 0; b < 4; b++) begin
        all_diff = 1;
        for (int j = 0; j < D; j++) if (hist[hist.size() - 2 - j][b] == m_lvl[b]) all_diff = 0;
        m_press[b] = all_diff && m_lvl[b];
        if (all_diff) m_lvl[b] = !m_lvl[b];
      end
      hist.push_back(btn_n);
      void'(hist.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    btn_n = ~m;
    cyc(D + 6);
    btn_n = 4'hF;
    cyc(D + 6);
  endtask

  task automatic test_reset();
    checks++; if (display_value !== 16'h0000) begin errors++; $display("FAIL reset_display got=%h exp=0000", display_value); end
    checks++; if (view_sel !== 2'd0) begin errors++; $display("FAIL reset_view got=%0d exp=0", view_sel); end
    checks++; if (auto_on !== 1'b0) begin errors++; $display("FAIL reset_auto got=%b exp=0", auto_on); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL reset_frozen got=%b exp=0", frozen); end
    pc = 16'h1234;
    reset = 1'b1;
    cyc(2);
    checks++; if (display_value !== 16'h1234) begin errors++; $display("FAIL idle_display got=%h exp=1234", display_value); end
    checks++; if ({view_sel, auto_on, frozen} !== 4'b0000) begin errors++; $display("FAIL idle_state got=%b exp=0000", {view_sel, auto_on, frozen}); end
  endtask

  task automatic test_debounce();
    a = 8'h3C;
    for (int g = 0; g < 3; g++) begin
      btn_n[0] = 1'b0; cyc(2);
      btn_n[0] = 1'b1; cyc(3);
    end
    cyc(6);
    checks++; if (view_sel !== 2'd0) begin errors++; $display("FAIL glitch_view got=%0d exp=0", view_sel); end
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (k == 6) begin checks++; if (view_sel !== 2'd0) begin errors++; $display("FAIL deb_edge6 got=%0d exp=0", view_sel); end end
      if (k == 7) begin
        checks++; if (view_sel !== 2'd1) begin errors++; $display("FAIL deb_edge7 got=%0d exp=1", view_sel); end
        checks++; if (display_value !== 16'h1234) begin errors++; $display("FAIL deb_disp7 got=%h exp=1234", display_value); end
      end
      if (k == 8) begin checks++; if (display_value !== 16'h003C) begin errors++; $display("FAIL deb_disp8 got=%h exp=003c", display_value); end end
    end
    btn_n[0] = 1'b1;
    cyc(D + 6);
  endtask

  task automatic test_down();
    for (int i = 0; i < 3; i++) press(4'b0001);
    checks++; if (view_sel !== 2'd0) begin errors++; $display("FAIL up_wrap got=%0d exp=0", view_sel); end
    for (int i = 1; i <= 4; i++) begin
      press(4'b0010);
      checks++; if (view_sel !== 2'((4 - i) % 4)) begin errors++; $display("FAIL down_%0d got=%0d exp=%0d", i, view_sel, (4 - i) % 4); end
    end
    press(4'b0011);
    checks++; if (view_sel !== 2'd0) begin errors++; $display("FAIL both_v0 got=%0d exp=0", view_sel); end
    press(4'b0001);
    press(4'b0011);
    checks++; if (view_sel !== 2'd1) begin errors++; $display("FAIL both_v1 got=%0d exp=1", view_sel); end
  endtask

  task automatic test_auto();
    int v0, e;
    v0 = 1;
    btn_n[3] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      if (k == 6) begin checks++; if (auto_on !== 1'b0) begin errors++; $display("FAIL auto_early got=%b exp=0", auto_on); end end
    end
    checks++; if (auto_on !== 1'b1) begin errors++; $display("FAIL auto_enter got=%b exp=1", auto_on); end
    btn_n[3] = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      cyc(1);
      e = k < 39 ? (v0 + k / 8) % 4 : k < 47 ? (v0 + 1) % 4 : (v0 + 2) % 4;
      checks++; if (view_sel !== 2'(e)) begin errors++; $display("FAIL rotate_k%0d got=%0d exp=%0d", k, view_sel, e); end
      checks++; if ({display_value, view_sel, auto_on, frozen} !== {m_disp, 2'(m_view), m_auto, m_frz})
        begin errors++; $display("FAIL auto_model_k%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", k, display_value, view_sel, auto_on, frozen, m_disp, m_view, m_auto, m_frz); end
      if (k == 32) btn_n[0] = 1'b0;
      if (k == 39) btn_n[0] = 1'b1;
    end
    press(4'b1000);
    checks++; if (auto_on !== 1'b0) begin errors++; $display("FAIL auto_exit got=%b exp=0", auto_on); end
    checks++; if (view_sel !== 2'(m_view)) begin errors++; $display("FAIL auto_exit_view got=%0d exp=%0d", view_sel, m_view); end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 4 && m_view != 1; i++) press(4'b0001);
    a = 8'h5A;
    press(4'b0100);
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL freeze_on got=%b exp=1", frozen); end
    checks++; if (display_value !== 16'h005A) begin errors++; $display("FAIL freeze_disp got=%h exp=005a", display_value); end
    a = 8'hFF;
    cyc(3);
    checks++; if (display_value !== 16'h005A) begin errors++; $display("FAIL freeze_hold got=%h exp=005a", display_value); end
    press(4'b0100);
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL freeze_off got=%b exp=0", frozen); end
    checks++; if (display_value !== 16'h00FF) begin errors++; $display("FAIL unfreeze_disp got=%h exp=00ff", display_value); end
  endtask

  task automatic test_reset_mid();
    press(4'b1000);
    press(4'b0100);
    checks++; if ({auto_on, frozen} !== 2'b11) begin errors++; $display("FAIL mid_setup got=%b exp=11", {auto_on, frozen}); end
    cyc(3);
    reset = 1'b0;
    cyc(1);
    checks++; if ({display_value, view_sel, auto_on, frozen} !== 20'h0)
      begin errors++; $display("FAIL mid_reset got=%h/%0d/%b/%b exp=0000/0/0/0", display_value, view_sel, auto_on, frozen); end
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_held_reset();
    btn_n = 4'b1110;
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    for (int k = 1; k <= D + 3; k++) begin
      cyc(1);
      if (k == D + 2) begin checks++; if (view_sel !== 2'd0) begin errors++; $display("FAIL held_early got=%0d exp=0", view_sel); end end
    end
    checks++; if (view_sel !== 2'd1) begin errors++; $display("FAIL held_press got=%0d exp=1", view_sel); end
    cyc(10);
    checks++; if (view_sel !== 2'd1) begin errors++; $display("FAIL held_once got=%0d exp=1", view_sel); end
    btn_n = 4'hF;
    cyc(D + 6);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      cyc(1);
      checks++; if ({display_value, view_sel, auto_on, frozen} !== {m_disp, 2'(m_view), m_auto, m_frz})
        begin errors++; $display("FAIL rand_%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", n, display_value, view_sel, auto_on, frozen, m_disp, m_view, m_auto, m_frz); end
      reset = $urandom_range(0, 399) != 0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) btn_n[b] = ~btn_n[b];
      pc = 16'($urandom);
      a = 8'($urandom);
      x = 8'($urandom);
      y = 8'($urandom);
    end
    reset = 1'b1;
    btn_n = 4'hF;
    cyc(2);
  endtask

  initial begin
    reset = 1'b0;
    btn_n = 4'hF;
    cyc(3);
    test_reset();
    test_debounce();
    test_down();
    test_auto();
    test_freeze();
    test_reset_mid();
    test_held_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
